// File: rtl/mux2x1.sv
// mux2x1: 2:1 word mux with a combinational output and a
// valid-qualified registered copy of the same selection.
//
// Ports:
//   clk       in   rising-edge clock for the registered path
//   rst       in   asynchronous active-high reset
//   a         in   [WIDTH] data picked when sel=0
//   b         in   [WIDTH] data picked when sel=1
//   sel       in   select: 0 -> a, 1 -> b
//   in_valid  in   qualifies capture into out_q
//   out       out  [WIDTH] combinational mux result
//   out_q     out  [WIDTH] registered mux result
//   out_valid out  one-cycle pulse after each capture
module mux2x1 #(
  parameter int unsigned      WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  // Whole-word select; the registered path reuses it so
  // both outputs always agree on the chosen source.
  assign out = sel ? b : a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= RST_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_mux2x1.sv
// tb_mux2x1: directed checks of the combinational and
// registered paths for WIDTH=2 and WIDTH=8/RST_VAL=A5.
module tb_mux2x1;

  logic       clk;
  logic       rst;
  logic [1:0] a;
  logic [1:0] b;
  logic       sel;
  logic       in_valid;
  logic [1:0] out;
  logic [1:0] out_q;
  logic       out_valid;

  logic [7:0] a8;
  logic [7:0] b8;
  logic       sel8;
  logic       iv8;
  logic [7:0] out8;
  logic [7:0] out_q8;
  logic       ov8;

  int checks;
  int errors;

  mux2x1 #(.WIDTH(2), .RST_VAL(2'b00)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid)
  );

  mux2x1 #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .a        (a8),
    .b        (b8),
    .sel      (sel8),
    .in_valid (iv8),
    .out      (out8),
    .out_q    (out_q8),
    .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    a        = 2'b00;
    b        = 2'b00;
    sel      = 1'b0;
    in_valid = 1'b0;
    a8       = 8'h00;
    b8       = 8'h00;
    sel8     = 1'b0;
    iv8      = 1'b0;
    #2;
    chk("rst_out_q", 64'(out_q), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_q8", 64'(out_q8), 64'hA5);

    // Combinational vectors, applied while rst=1.
    a = 2'b01; b = 2'b11; sel = 1'b0; #1;
    chk("comb_v1", 64'(out), 64'h1);
    sel = 1'b1; #1;
    chk("comb_v2", 64'(out), 64'h3);
    b = 2'b10; #1;
    chk("comb_v3", 64'(out), 64'h2);
    a = 2'b10; b = 2'b11; sel = 1'b0; #1;
    chk("comb_v4", 64'(out), 64'h2);
    a = 2'b00; #1;
    chk("comb_v5", 64'(out), 64'h0);
    a = 2'b01; b = 2'b00; sel = 1'b1; #1;
    chk("comb_v6", 64'(out), 64'h0);

    // Reset dominates clock and in_valid.
    a = 2'b11; sel = 1'b0; in_valid = 1'b1;
    tick();
    chk("rst_hold_q", 64'(out_q), 64'h0);
    chk("rst_hold_v", 64'(out_valid), 64'h0);
    in_valid = 1'b0;
    rst = 1'b0;

    // First capture after reset.
    a = 2'b01; b = 2'b11; sel = 1'b1; in_valid = 1'b1;
    tick();
    chk("cap_q", 64'(out_q), 64'h3);
    chk("cap_v", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    tick();
    chk("cap_v_drop", 64'(out_valid), 64'h0);
    chk("cap_q_keep", 64'(out_q), 64'h3);

    // Hold with in_valid=0 while inputs move.
    a = 2'b00; b = 2'b01; sel = 1'b0; #1;
    chk("hold_out1", 64'(out), 64'h0);
    tick();
    chk("hold_q1", 64'(out_q), 64'h3);
    sel = 1'b1; #1;
    chk("hold_out2", 64'(out), 64'h1);
    tick();
    chk("hold_q2", 64'(out_q), 64'h3);
    a = 2'b10; sel = 1'b0; #1;
    chk("hold_out3", 64'(out), 64'h2);
    tick();
    chk("hold_q3", 64'(out_q), 64'h3);

    // Async reset between edges with out_q=10.
    a = 2'b10; sel = 1'b0; in_valid = 1'b1;
    tick();
    chk("pre_ar_q", 64'(out_q), 64'h2);
    chk("pre_ar_v", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_q", 64'(out_q), 64'h0);
    chk("ar_v", 64'(out_valid), 64'h0);
    chk("ar_out", 64'(out), 64'h2);
    tick();
    rst = 1'b0;

    // Reset in the same cycle as in_valid=1.
    a = 2'b11; sel = 1'b0; in_valid = 1'b1;
    #3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_q", 64'(out_q), 64'h0);
    chk("mid_rst_v", 64'(out_valid), 64'h0);
    tick();
    chk("mid_rst_v2", 64'(out_valid), 64'h0);
    chk("mid_rst_q2", 64'(out_q), 64'h0);

    // Streaming, no bubbles.
    a = 2'b01; b = 2'b10; in_valid = 1'b1;
    sel = 1'b0;
    tick();
    chk("st_q0", 64'(out_q), 64'h1);
    chk("st_v0", 64'(out_valid), 64'h1);
    sel = 1'b1;
    tick();
    chk("st_q1", 64'(out_q), 64'h2);
    chk("st_v1", 64'(out_valid), 64'h1);
    sel = 1'b0;
    tick();
    chk("st_q2", 64'(out_q), 64'h1);
    chk("st_v2", 64'(out_valid), 64'h1);
    sel = 1'b1;
    tick();
    chk("st_q3", 64'(out_q), 64'h2);
    chk("st_v3", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    tick();
    chk("st_end_v", 64'(out_valid), 64'h0);
    chk("st_end_q", 64'(out_q), 64'h2);

    // Wide instance with non-zero reset value.
    rst = 1'b1;
    #1;
    chk("w_rst_q", 64'(out_q8), 64'hA5);
    chk("w_rst_v", 64'(ov8), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("w_idle_q", 64'(out_q8), 64'hA5);
    a8 = 8'h3C; b8 = 8'hC3; sel8 = 1'b1; iv8 = 1'b1;
    #1;
    chk("w_out", 64'(out8), 64'hC3);
    tick();
    chk("w_cap_q", 64'(out_q8), 64'hC3);
    chk("w_cap_v", 64'(ov8), 64'h1);
    iv8 = 1'b0;
    sel8 = 1'b0;
    tick();
    chk("w_hold_q", 64'(out_q8), 64'hC3);
    chk("w_out_a", 64'(out8), 64'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
